ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline.sv | 161 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: control path of a 5-stage in-order pipeline.
// Carries decoded control words from ID through EX, MEM and WB. It also
// detects load-use and branch-operand hazards, which stall IF/ID and
// inject a bubble into EX. It selects ALU operand forwarding from MEM/WB.
//
// Ports:
//   clk                          clock, rising edge
//   reset                        asynchronous active-high reset
//   controlSignals_ID[7:0]       {regDst, regWrite, aluSrc, memWrite, memRead, aluOp[2:0]}
//   pcSrc_IF                     branch taken
//   rs_ID, rt_ID, rd_ID[4:0]     register fields of the instruction in ID
//   regDst_EX, aluSrc_EX, aluOp_EX, writeReg_EX    EX-stage controls / destination
//   forwardA_EX, forwardB_EX     00 regfile, 10 MEM, 01 WB
//   memWrite_MEM, memRead_MEM, writeReg_MEM        MEM-stage controls / destination
//   regWrite_WB, memToReg_WB, writeReg_WB          WB-stage controls / destination
//   pcWrite, ifIdWrite, ifIdFlush, stall_ID        PC and IF/ID control
module ctrl_pipeline (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] controlSignals_ID,
    input  logic       pcSrc_IF,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic [4:0] rd_ID,
    output logic       regDst_EX,
    output logic       aluSrc_EX,
    output logic [2:0] aluOp_EX,
    output logic [4:0] writeReg_EX,
    output logic [1:0] forwardA_EX,
    output logic [1:0] forwardB_EX,
    output logic       memWrite_MEM,
    output logic       memRead_MEM,
    output logic [4:0] writeReg_MEM,
    output logic       regWrite_WB,
    output logic       memToReg_WB,
    output logic [4:0] writeReg_WB,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       ifIdFlush,
    output logic       stall_ID
);

    // ID/EX state not visible as ports
    logic       regWriteEx;
    logic       memWriteEx;
    logic       memReadEx;
    logic [4:0] rsEx;
    logic [4:0] rtEx;
    logic [4:0] rdEx;

    // EX/MEM state not visible as ports
    logic       regWriteMem;

    // Hazard detection terms
    logic       branchId;
    logic       exMatchesId;
    logic       memMatchesId;
    logic       loadUseHazard;
    logic       branchHazard;

    // ID/EX register; a stall replaces the captured word with an all-zero bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regDst_EX  <= 1'b0;
            regWriteEx <= 1'b0;
            aluSrc_EX  <= 1'b0;
            memWriteEx <= 1'b0;
            memReadEx  <= 1'b0;
            aluOp_EX   <= 3'd0;
            rsEx       <= 5'd0;
            rtEx       <= 5'd0;
            rdEx       <= 5'd0;
        end else if (stall_ID) begin
            regDst_EX  <= 1'b0;
            regWriteEx <= 1'b0;
            aluSrc_EX  <= 1'b0;
            memWriteEx <= 1'b0;
            memReadEx  <= 1'b0;
            aluOp_EX   <= 3'd0;
            rsEx       <= 5'd0;
            rtEx       <= 5'd0;
            rdEx       <= 5'd0;
        end else begin
            regDst_EX  <= controlSignals_ID[7];
            regWriteEx <= controlSignals_ID[6];
            aluSrc_EX  <= controlSignals_ID[5];
            memWriteEx <= controlSignals_ID[4];
            memReadEx  <= controlSignals_ID[3];
            aluOp_EX   <= controlSignals_ID[2:0];
            rsEx       <= rs_ID;
            rtEx       <= rt_ID;
            rdEx       <= rd_ID;
        end
    end

    always_comb begin
        writeReg_EX = regDst_EX ? rdEx : rtEx;
    end

    // EX/MEM register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteMem  <= 1'b0;
            memWrite_MEM <= 1'b0;
            memRead_MEM  <= 1'b0;
            writeReg_MEM <= 5'd0;
        end else begin
            regWriteMem  <= regWriteEx;
            memWrite_MEM <= memWriteEx;
            memRead_MEM  <= memReadEx;
            writeReg_MEM <= writeReg_EX;
        end
    end

    // MEM/WB register; only loads write back from memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWrite_WB <= 1'b0;
            memToReg_WB <= 1'b0;
            writeReg_WB <= 5'd0;
        end else begin
            regWrite_WB <= regWriteMem;
            memToReg_WB <= memRead_MEM;
            writeReg_WB <= writeReg_MEM;
        end
    end

    // Hazard detection; r0 is hard-wired zero and never creates a dependency
    always_comb begin
        branchId      = (controlSignals_ID == 8'b0000_0001);
        exMatchesId   = (writeReg_EX != 5'd0) &&
                        ((writeReg_EX == rs_ID) || (writeReg_EX == rt_ID));
        memMatchesId  = (writeReg_MEM != 5'd0) &&
                        ((writeReg_MEM == rs_ID) || (writeReg_MEM == rt_ID));
        loadUseHazard = memReadEx && exMatchesId;
        // Branches compare in ID, so they must also wait out a load in MEM
        branchHazard  = branchId && ((regWriteEx && exMatchesId) ||
                                     (memRead_MEM && memMatchesId));
        stall_ID      = loadUseHazard || branchHazard;
        pcWrite       = ~stall_ID;
        ifIdWrite     = ~stall_ID;
        ifIdFlush     = pcSrc_IF & ~stall_ID;
    end

    // Forwarding: MEM holds the younger result, so it wins over WB
    always_comb begin
        forwardA_EX = 2'b00;
        forwardB_EX = 2'b00;
        if (regWriteMem && (writeReg_MEM != 5'd0) && (writeReg_MEM == rsEx)) begin
            forwardA_EX = 2'b10;
        end else if (regWrite_WB && (writeReg_WB != 5'd0) && (writeReg_WB == rsEx)) begin
            forwardA_EX = 2'b01;
        end
        if (regWriteMem && (writeReg_MEM != 5'd0) && (writeReg_MEM == rtEx)) begin
            forwardB_EX = 2'b10;
        end else if (regWrite_WB && (writeReg_WB != 5'd0) && (writeReg_WB == rtEx)) begin
            forwardB_EX = 2'b01;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed-vector bench for ctrl_pipeline.
module tb_ctrl_pipeline;

    logic       clk;
    logic       reset;
    logic [7:0] controlSignals_ID;
    logic       pcSrc_IF;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic [4:0] rd_ID;
    logic       regDst_EX;
    logic       aluSrc_EX;
    logic [2:0] aluOp_EX;
    logic [4:0] writeReg_EX;
    logic [1:0] forwardA_EX;
    logic [1:0] forwardB_EX;
    logic       memWrite_MEM;
    logic       memRead_MEM;
    logic [4:0] writeReg_MEM;
    logic       regWrite_WB;
    logic       memToReg_WB;
    logic [4:0] writeReg_WB;
    logic       pcWrite;
    logic       ifIdWrite;
    logic       ifIdFlush;
    logic       stall_ID;

    int nVectors = 0;
    int nMiscompares = 0;

    ctrl_pipeline dut (
        .clk              (clk),
        .reset            (reset),
        .controlSignals_ID(controlSignals_ID),
        .pcSrc_IF         (pcSrc_IF),
        .rs_ID            (rs_ID),
        .rt_ID            (rt_ID),
        .rd_ID            (rd_ID),
        .regDst_EX        (regDst_EX),
        .aluSrc_EX        (aluSrc_EX),
        .aluOp_EX         (aluOp_EX),
        .writeReg_EX      (writeReg_EX),
        .forwardA_EX      (forwardA_EX),
        .forwardB_EX      (forwardB_EX),
        .memWrite_MEM     (memWrite_MEM),
        .memRead_MEM      (memRead_MEM),
        .writeReg_MEM     (writeReg_MEM),
        .regWrite_WB      (regWrite_WB),
        .memToReg_WB      (memToReg_WB),
        .writeReg_WB      (writeReg_WB),
        .pcWrite          (pcWrite),
        .ifIdWrite        (ifIdWrite),
        .ifIdFlush        (ifIdFlush),
        .stall_ID         (stall_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setId(input logic [7:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        controlSignals_ID = ctrl;
        rs_ID = rs;
        rt_ID = rt;
        rd_ID = rd;
    endtask

    // Advance one clock; sample 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        pcSrc_IF = 1'b1;
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        #2;
        checkEq("rst regDst_EX", 8'(regDst_EX), 8'd0);
        checkEq("rst aluSrc_EX", 8'(aluSrc_EX), 8'd0);
        checkEq("rst writeReg_EX", 8'(writeReg_EX), 8'd0);
        checkEq("rst forwardA", 8'(forwardA_EX), 8'd0);
        checkEq("rst memRead_MEM", 8'(memRead_MEM), 8'd0);
        checkEq("rst regWrite_WB", 8'(regWrite_WB), 8'd0);
        checkEq("rst stall", 8'(stall_ID), 8'd0);
        checkEq("rst pcWrite", 8'(pcWrite), 8'd1);
        checkEq("rst ifIdWrite", 8'(ifIdWrite), 8'd1);
        checkEq("rst flush hi", 8'(ifIdFlush), 8'd1);
        pcSrc_IF = 1'b0;
        #1;
        checkEq("rst flush lo", 8'(ifIdFlush), 8'd0);
        tick();
        reset = 1'b0;

        // ADD r3 then two readers: MEM forward, then WB forward
        setId(8'hC0, 5'd1, 5'd2, 5'd3);
        tick();
        checkEq("add regDst_EX", 8'(regDst_EX), 8'd1);
        checkEq("add writeReg_EX", 8'(writeReg_EX), 8'd3);
        setId(8'hC0, 5'd3, 5'd4, 5'd6);
        #1;
        checkEq("add no stall", 8'(stall_ID), 8'd0);
        tick();
        checkEq("fwdA mem", 8'(forwardA_EX), 8'b10);
        checkEq("fwdB none", 8'(forwardB_EX), 8'b00);
        checkEq("writeReg_MEM", 8'(writeReg_MEM), 8'd3);
        setId(8'hC0, 5'd3, 5'd3, 5'd7);
        tick();
        checkEq("fwdA wb", 8'(forwardA_EX), 8'b01);
        checkEq("fwdB wb", 8'(forwardB_EX), 8'b01);
        checkEq("regWrite_WB", 8'(regWrite_WB), 8'd1);
        checkEq("writeReg_WB", 8'(writeReg_WB), 8'd3);
        checkEq("memToReg_WB add", 8'(memToReg_WB), 8'd0);
        setId(8'hC0, 5'd7, 5'd6, 5'd7);
        tick();
        checkEq("fwdA mem r7", 8'(forwardA_EX), 8'b10);
        checkEq("fwdB wb r6", 8'(forwardB_EX), 8'b01);
        // Writes r0; next instruction reads r7 with MEM and WB both holding r7
        setId(8'hC0, 5'd7, 5'd0, 5'd0);
        tick();
        checkEq("fwdA mem prio", 8'(forwardA_EX), 8'b10);
        checkEq("fwdB r0", 8'(forwardB_EX), 8'b00);
        // Reader of r0 behind a write to r0
        setId(8'hC0, 5'd0, 5'd0, 5'd1);
        #1;
        checkEq("r0 no stall", 8'(stall_ID), 8'd0);
        tick();
        checkEq("r0 fwdA", 8'(forwardA_EX), 8'b00);
        drain();

        // LW r5 then dependent ADD: one bubble, then WB forward
        setId(8'h68, 5'd1, 5'd5, 5'd0);
        tick();
        checkEq("lw aluSrc_EX", 8'(aluSrc_EX), 8'd1);
        checkEq("lw writeReg_EX", 8'(writeReg_EX), 8'd5);
        setId(8'hC0, 5'd5, 5'd2, 5'd8);
        #1;
        checkEq("lu stall", 8'(stall_ID), 8'd1);
        checkEq("lu pcWrite", 8'(pcWrite), 8'd0);
        checkEq("lu ifIdWrite", 8'(ifIdWrite), 8'd0);
        tick();
        checkEq("bubble aluSrc", 8'(aluSrc_EX), 8'd0);
        checkEq("bubble regDst", 8'(regDst_EX), 8'd0);
        checkEq("bubble writeReg", 8'(writeReg_EX), 8'd0);
        checkEq("lw memRead_MEM", 8'(memRead_MEM), 8'd1);
        checkEq("lu stall off", 8'(stall_ID), 8'd0);
        checkEq("lu pcWrite on", 8'(pcWrite), 8'd1);
        tick();
        checkEq("lu fwdA wb", 8'(forwardA_EX), 8'b01);
        checkEq("lw memToReg_WB", 8'(memToReg_WB), 8'd1);
        checkEq("lw writeReg_WB", 8'(writeReg_WB), 8'd5);
        // Load into r0 followed by reader of r0 must not stall
        setId(8'h68, 5'd1, 5'd0, 5'd0);
        tick();
        setId(8'hC0, 5'd0, 5'd0, 5'd9);
        #1;
        checkEq("lw r0 no stall", 8'(stall_ID), 8'd0);
        drain();

        // ADDI r4 then BEQ on r4 with branch taken
        setId(8'h60, 5'd1, 5'd4, 5'd0);
        tick();
        setId(8'h01, 5'd4, 5'd9, 5'd0);
        pcSrc_IF = 1'b1;
        #1;
        checkEq("beq ex stall", 8'(stall_ID), 8'd1);
        checkEq("beq flush masked", 8'(ifIdFlush), 8'd0);
        tick();
        checkEq("beq stall off", 8'(stall_ID), 8'd0);
        checkEq("beq flush", 8'(ifIdFlush), 8'd1);
        pcSrc_IF = 1'b0;
        drain();

        // LW r2 then BEQ on rt=2: EX hazard then MEM hazard
        setId(8'h68, 5'd1, 5'd2, 5'd0);
        tick();
        setId(8'h01, 5'd3, 5'd2, 5'd0);
        #1;
        checkEq("lwbeq stall1", 8'(stall_ID), 8'd1);
        tick();
        checkEq("lwbeq stall2", 8'(stall_ID), 8'd1);
        tick();
        checkEq("lwbeq stall off", 8'(stall_ID), 8'd0);
        drain();

        // SW in EX, reset pulsed mid-cycle
        setId(8'h30, 5'd1, 5'd2, 5'd0);
        tick();
        checkEq("sw aluSrc_EX", 8'(aluSrc_EX), 8'd1);
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        #1;
        reset = 1'b1;
        #1;
        checkEq("async aluSrc_EX", 8'(aluSrc_EX), 8'd0);
        checkEq("async writeReg_EX", 8'(writeReg_EX), 8'd0);
        checkEq("async regWrite_WB", 8'(regWrite_WB), 8'd0);
        tick();
        checkEq("rst memWrite_MEM", 8'(memWrite_MEM), 8'd0);
        setId(8'hC0, 5'd0, 5'd0, 5'd3);
        reset = 1'b0;
        tick();
        checkEq("post-rst memWrite", 8'(memWrite_MEM), 8'd0);
        checkEq("post-rst regDst", 8'(regDst_EX), 8'd1);
        checkEq("post-rst writeReg", 8'(writeReg_EX), 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
